// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: instruction class codes, FSM states and
// register-file constants.
package pipeline_defs;

  typedef enum logic [3:0] {
    InstNop    = 4'd0,
    InstRtype  = 4'd1,
    InstItype  = 4'd2,
    InstLoad   = 4'd3,
    InstStore  = 4'd4,
    InstBranch = 4'd5,
    InstJump   = 4'd6,
    InstJal    = 4'd7,
    InstHalt   = 4'd15
  } inst_type_e;

  typedef enum logic {
    StRun    = 1'b0,
    StHalted = 1'b1
  } wb_state_e;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] RegZero = '0;

  function automatic logic is_writing_type(input logic [3:0] inst_type);
    return (inst_type == InstRtype) || (inst_type == InstItype) ||
           (inst_type == InstLoad)  || (inst_type == InstJal);
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// MEM/WB pipeline register bundle as seen by the writeback stage.
interface writeback_stage_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [31:0]           inst;
    logic [31:0]           new_pc;
    logic [DATA_WIDTH-1:0] alu_output;
    logic [3:0]            inst_num;
    logic [3:0]            inst_type;

    modport master (output inst, new_pc, alu_output, inst_num, inst_type);
    modport slave  (input  inst, new_pc, alu_output, inst_num, inst_type);
endinterface

// File: rtl/writeback_stage_regfile.sv
// Architectural register file: one write port, raw (unbypassed) read ports for ID and debug.
// Entry 0 is never written and always reads as zero.
module regfile_2r1w
    import pipeline_defs::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_COUNT  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    input  logic [REG_ADDR_W-1:0] raddr_dbg,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic [DATA_WIDTH-1:0] rdata_dbg
);

    logic [DATA_WIDTH-1:0] mem_q [REG_COUNT];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && (waddr != RegZero)) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a   = (raddr_a   == RegZero) ? '0 : mem_q[raddr_a];
        rdata_b   = (raddr_b   == RegZero) ? '0 : mem_q[raddr_b];
        rdata_dbg = (raddr_dbg == RegZero) ? '0 : mem_q[raddr_dbg];
    end

endmodule

// File: rtl/writeback_stage.sv
// WB stage: decodes the MEM/WB bundle into a register write, bypasses it to the ID read
// ports, counts retired instructions and stops permanently on HALT until reset.
module writeback_stage
    import pipeline_defs::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned LINK_REG   = 31,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    writeback_stage_if.slave      memwb,
    input  logic [REG_ADDR_W-1:0] FromID_AddrA,
    input  logic [REG_ADDR_W-1:0] FromID_AddrB,
    output logic [DATA_WIDTH-1:0] ToID_DataA,
    output logic [DATA_WIDTH-1:0] ToID_DataB,
    input  logic [REG_ADDR_W-1:0] FromDbg_Addr,
    output logic [DATA_WIDTH-1:0] ToDbg_Data,
    output logic                  ToFWD_WriteEn,
    output logic [REG_ADDR_W-1:0] ToFWD_WriteAddr,
    output logic [DATA_WIDTH-1:0] ToFWD_WriteData,
    output logic [CNT_WIDTH-1:0]  ToStat_RetireCount,
    output logic [3:0]            ToStat_LastInstNum,
    output logic                  ToStat_Halted
);

    wb_state_e             state_q, state_d;
    logic [CNT_WIDTH-1:0]  retire_cnt_q, retire_cnt_d;
    logic [3:0]            last_num_q, last_num_d;

    logic [REG_ADDR_W-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_en;
    logic                  retire;
    logic [DATA_WIDTH-1:0] raw_a, raw_b;

    // Only the rd/rt fields of the instruction word matter here.
    logic unused_inst;
    assign unused_inst = ^{memwb.inst[31:21], memwb.inst[10:0]};

    always_comb begin
        write_addr = RegZero;
        write_data = '0;
        case (memwb.inst_type)
            InstRtype: begin
                write_addr = memwb.inst[15:11];
                write_data = DATA_WIDTH'(memwb.alu_output);
            end
            InstItype, InstLoad: begin
                write_addr = memwb.inst[20:16];
                write_data = DATA_WIDTH'(memwb.alu_output);
            end
            InstJal: begin
                write_addr = REG_ADDR_W'(LINK_REG);
                write_data = DATA_WIDTH'(memwb.new_pc);
            end
            default: ;
        endcase
    end

    assign write_en = (state_q == StRun) && is_writing_type(memwb.inst_type) &&
                      (write_addr != RegZero);
    assign retire   = (state_q == StRun) && (memwb.inst_type != InstNop);

    regfile_2r1w #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_regfile (
        .clock      (clock),
        .reset      (reset),
        .we         (write_en),
        .waddr      (write_addr),
        .wdata      (write_data),
        .raddr_a    (FromID_AddrA),
        .raddr_b    (FromID_AddrB),
        .raddr_dbg  (FromDbg_Addr),
        .rdata_a    (raw_a),
        .rdata_b    (raw_b),
        .rdata_dbg  (ToDbg_Data)
    );

    // ID sees this cycle's write immediately; the array only updates at the next edge.
    always_comb begin
        ToID_DataA = raw_a;
        ToID_DataB = raw_b;
        if (FromID_AddrA == RegZero) begin
            ToID_DataA = '0;
        end else if (write_en && (FromID_AddrA == write_addr)) begin
            ToID_DataA = write_data;
        end
        if (FromID_AddrB == RegZero) begin
            ToID_DataB = '0;
        end else if (write_en && (FromID_AddrB == write_addr)) begin
            ToID_DataB = write_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        retire_cnt_d = retire_cnt_q;
        last_num_d   = last_num_q;
        if (retire) begin
            last_num_d = memwb.inst_num;
            if (retire_cnt_q != '1) begin
                retire_cnt_d = retire_cnt_q + CNT_WIDTH'(1);
            end
        end
        if ((state_q == StRun) && (memwb.inst_type == InstHalt)) begin
            state_d = StHalted;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StRun;
            retire_cnt_q <= '0;
            last_num_q   <= '0;
        end else begin
            state_q      <= state_d;
            retire_cnt_q <= retire_cnt_d;
            last_num_q   <= last_num_d;
        end
    end

    assign ToFWD_WriteEn      = write_en;
    assign ToFWD_WriteAddr    = write_addr;
    assign ToFWD_WriteData    = write_data;
    assign ToStat_RetireCount = retire_cnt_q;
    assign ToStat_LastInstNum = last_num_q;
    assign ToStat_Halted      = (state_q == StHalted);

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage; expectations go through a scoreboard queue.
module tb_writeback_stage;
    import pipeline_defs::*;

    logic        clock;
    logic        reset;
    logic [4:0]  addr_a, addr_b, dbg_addr;
    logic [31:0] data_a, data_b, dbg_data, wdata;
    logic        wen, halted;
    logic [4:0]  waddr;
    logic [31:0] rcount;
    logic [3:0]  last_num;

    logic [31:0] c4_data_a, c4_data_b, c4_dbg, c4_wdata;
    logic        c4_wen, c4_halted;
    logic [4:0]  c4_waddr;
    logic [3:0]  c4_rcount, c4_last;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    writeback_stage_if #(.DATA_WIDTH(32)) memwb ();

    writeback_stage dut (
        .clock              (clock),
        .reset              (reset),
        .memwb              (memwb),
        .FromID_AddrA       (addr_a),
        .FromID_AddrB       (addr_b),
        .ToID_DataA         (data_a),
        .ToID_DataB         (data_b),
        .FromDbg_Addr       (dbg_addr),
        .ToDbg_Data         (dbg_data),
        .ToFWD_WriteEn      (wen),
        .ToFWD_WriteAddr    (waddr),
        .ToFWD_WriteData    (wdata),
        .ToStat_RetireCount (rcount),
        .ToStat_LastInstNum (last_num),
        .ToStat_Halted      (halted)
    );

    writeback_stage #(.CNT_WIDTH(4)) dut_c4 (
        .clock              (clock),
        .reset              (reset),
        .memwb              (memwb),
        .FromID_AddrA       (addr_a),
        .FromID_AddrB       (addr_b),
        .ToID_DataA         (c4_data_a),
        .ToID_DataB         (c4_data_b),
        .FromDbg_Addr       (dbg_addr),
        .ToDbg_Data         (c4_dbg),
        .ToFWD_WriteEn      (c4_wen),
        .ToFWD_WriteAddr    (c4_waddr),
        .ToFWD_WriteData    (c4_wdata),
        .ToStat_RetireCount (c4_rcount),
        .ToStat_LastInstNum (c4_last),
        .ToStat_Halted      (c4_halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: observed %h required an expectation", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive(input logic [3:0] t, input logic [31:0] inst, input logic [31:0] npc,
                         input logic [31:0] alu, input logic [3:0] num);
        memwb.inst_type  = t;
        memwb.inst       = inst;
        memwb.new_pc     = npc;
        memwb.alu_output = alu;
        memwb.inst_num   = num;
    endtask

    task automatic nop();
        drive(InstNop, 32'h0, 32'h0, 32'h0, 4'd0);
    endtask

    // Apply stimulus away from the edge, let the clock commit it, then go idle.
    task automatic commit();
        @(posedge clock);
        #1;
        nop();
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd);
        return {16'h0, rd, 11'h0};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] rt);
        return {11'h0, rt, 16'h0};
    endfunction

    initial begin
        reset    = 1'b0;
        addr_a   = 5'd0;
        addr_b   = 5'd0;
        dbg_addr = 5'd0;
        nop();

        // Reset state
        #12;
        push("reset_count", 32'd0);   check(rcount);
        push("reset_halted", 32'd0);  check({31'd0, halted});
        push("reset_last", 32'd0);    check({28'd0, last_num});
        @(negedge clock);
        reset = 1'b1;
        for (int a = 0; a < 32; a++) begin
            addr_a = 5'(a);
            addr_b = 5'(31 - a);
            push("reset_read_a", 32'd0);
            push("reset_read_b", 32'd0);
            #1;
            check(data_a);
            check(data_b);
        end

        // RTYPE write with same-cycle bypass
        @(negedge clock);
        addr_a = 5'd5;
        drive(InstRtype, rtype(5'd5), 32'h0, 32'hDEADBEEF, 4'd1);
        push("rtype_bypass", 32'hDEADBEEF);
        push("rtype_wen", 32'd1);
        push("rtype_waddr", 32'd5);
        #1;
        check(data_a);
        check({31'd0, wen});
        check({27'd0, waddr});
        push("rtype_array", 32'hDEADBEEF);
        push("rtype_count", 32'd1);
        push("rtype_last", 32'd1);
        commit();
        check(data_a);
        check(rcount);
        check({28'd0, last_num});

        // ITYPE targeting r0: retires but writes nothing
        @(negedge clock);
        addr_a = 5'd0;
        drive(InstItype, itype(5'd0), 32'h0, 32'h1234, 4'd2);
        push("itype_r0_wen", 32'd0);
        #1;
        check({31'd0, wen});
        push("itype_r0_read", 32'd0);
        push("itype_count", 32'd2);
        commit();
        check(data_a);
        check(rcount);

        // JAL writes the link register with NewPC
        @(negedge clock);
        addr_b = 5'd31;
        drive(InstJal, 32'h0, 32'h40, 32'hFFFF_FFFF, 4'd3);
        push("jal_waddr", 32'd31);
        push("jal_wdata", 32'h40);
        #1;
        check({27'd0, waddr});
        check(wdata);
        push("jal_r31", 32'h40);
        push("jal_count", 32'd3);
        commit();
        check(data_b);
        check(rcount);

        // STORE retires without writing
        @(negedge clock);
        drive(InstStore, rtype(5'd31), 32'h0, 32'h5555, 4'd4);
        push("store_wen", 32'd0);
        #1;
        check({31'd0, wen});
        push("store_r31", 32'h40);
        push("store_count", 32'd4);
        push("store_last", 32'd4);
        commit();
        check(data_b);
        check(rcount);
        check({28'd0, last_num});

        // HALT retires, then everything freezes
        @(negedge clock);
        drive(InstHalt, 32'h0, 32'h0, 32'h0, 4'd9);
        push("halt_flag", 32'd1);
        push("halt_last", 32'd9);
        push("halt_count", 32'd5);
        commit();
        check({31'd0, halted});
        check({28'd0, last_num});
        check(rcount);

        @(negedge clock);
        addr_a = 5'd3;
        drive(InstRtype, rtype(5'd3), 32'h0, 32'd7, 4'd10);
        push("halted_wen", 32'd0);
        push("halted_nobypass", 32'd0);
        #1;
        check({31'd0, wen});
        check(data_a);
        push("halted_r3", 32'd0);
        push("halted_count", 32'd5);
        push("halted_last", 32'd9);
        push("halted_sticky", 32'd1);
        commit();
        check(data_a);
        check(rcount);
        check({28'd0, last_num});
        check({31'd0, halted});

        dbg_addr = 5'd5;
        push("dbg_r5", 32'hDEADBEEF);
        #1;
        check(dbg_data);

        // Reset returns to RUN and clears the array
        reset = 1'b0;
        #1;
        push("rst_halted", 32'd0);
        push("rst_count", 32'd0);
        push("rst_dbg_r5", 32'd0);
        check({31'd0, halted});
        check(rcount);
        check(dbg_data);
        @(negedge clock);
        reset = 1'b1;

        // Saturation of a 4-bit retire counter
        addr_a = 5'd1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            drive(InstRtype, rtype(5'd1), 32'h0, 32'(n), 4'(n));
            commit();
            if (n == 15 || n == 20) begin
                push("sat_c4_count", 32'd15);
                check({28'd0, c4_rcount});
            end
        end
        push("sat_main_count", 32'd20);
        push("sat_r1", 32'd20);
        push("sat_c4_last", 32'd4);
        check(rcount);
        check(data_a);
        check({28'd0, c4_last});

        // Reset asserted while a write is pending discards it
        @(negedge clock);
        addr_a = 5'd4;
        drive(InstRtype, rtype(5'd4), 32'h0, 32'hAAAA_AAAA, 4'd11);
        push("pend_wen", 32'd1);
        #1;
        check({31'd0, wen});
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        nop();
        @(negedge clock);
        reset = 1'b1;
        #1;
        push("pend_r4", 32'd0);
        push("pend_r1", 32'd0);
        push("pend_count", 32'd0);
        check(data_a);
        addr_a = 5'd1;
        #1;
        check(data_a);
        check(rcount);

        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover: observed %0d entries required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
